serial_add_ctrl: RTL and testbench

Bit-serial adder/subtractor controller that sequences a single full-adder cell over WIDTH cycles to add or subtract two WIDTH-bit operands. It accepts a start request, shifts the operands LSB-first through the cell, accumulates the sum and raises a one-cycle done pulse with sum, carry-out and signed overflow. It sits between a requesting host and the one-bit adder datapath, trading area for latency.

---
 rtl/serial_add_pkg.sv | 14 +
 rtl/serial_add_ctrl_if.sv | 28 ++
 rtl/fa_cell.sv | 14 +
 rtl/serial_add_ctrl.sv | 105 ++++++++++
 tb/tb_serial_add_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller.
// State encoding and legal operand widths.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Host-side request/result bundle of the serial adder.
// master = requesting host, slave = controller.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, op_a, op_b, carry_in,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, op_a, op_b, carry_in,
    output busy, done, sum, carry_out, overflow
  );

endinterface

// File: rtl/fa_cell.sv
// One-bit full adder cell shared by every serial step.
// Purely combinational.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell
// sequenced LSB-first over WIDTH cycles.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  serial_add_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cmsb;
  logic             r_co;
  logic             r_busy;
  logic             r_done;

  logic w_s;
  logic w_co;
  logic w_accept;
  logic w_last;
  logic w_idle;

  fa_cell u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_c),
    .o_s    (w_s),
    .o_cout (w_co)
  );

  assign w_accept = bus.start
                  && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_cnt == LAST);
  assign w_idle   = (r_state == DONE) && !bus.start;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_cmsb  <= 1'b0;
      r_co    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (1'b1)
        w_accept: begin
          r_a     <= bus.op_a;
          r_b     <= bus.sub ? ~bus.op_b : bus.op_b;
          r_c     <= bus.sub | bus.carry_in;
          r_cnt   <= '0;
          r_state <= RUN;
          r_busy  <= 1'b1;
        end
        (r_state == RUN): begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_acc <= {w_s, r_acc[WIDTH-1:1]};
          r_c   <= w_co;
          r_cnt <= r_cnt + CW'(1);
          // r_c here is the carry into the MSB
          if (w_last) begin
            r_cmsb  <= r_c;
            r_co    <= w_co;
            r_sum   <= {w_s, r_acc[WIDTH-1:1]};
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        w_idle: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_co;
  assign bus.overflow  = r_cmsb ^ r_co;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl against
// an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input  logic [W-1:0] a,
                       input  logic [W-1:0] b,
                       input  logic s,
                       input  logic ci,
                       output logic [W-1:0] sm,
                       output logic co,
                       output logic ov);
    logic [W-1:0] bb;
    logic [W:0]   t;
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + (W+1)'(s ? 1'b1 : ci);
    sm = t[W-1:0];
    co = t[W];
    ov = (a[W-1] == bb[W-1]) && (sm[W-1] != a[W-1]);
  endtask

  task automatic drive(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic s,
                       input logic ci);
    bus.start    = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    bus.carry_in = ci;
  endtask

  task automatic scramble();
    bus.op_a     = W'($urandom);
    bus.op_b     = W'($urandom);
    bus.sub      = 1'($urandom);
    bus.carry_in = 1'($urandom);
  endtask

  task automatic run_op(input string tag,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic s,
                        input logic ci,
                        input logic [W-1:0] ex_s,
                        input logic ex_co,
                        input logic ex_ov,
                        input bit inject);
    int cyc;
    @(negedge clk);
    drive(a, b, s, ci);
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    chk({tag, " early done"}, 32'(bus.done), 32'd0);
    cyc = 0;
    while (!bus.done && cyc < 3 * W) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus.start = inject && (cyc == 3);
    end
    chk({tag, " latency"}, 32'(cyc), 32'(W));
    chk({tag, " sum"}, 32'(bus.sum), 32'(ex_s));
    chk({tag, " cout"}, 32'(bus.carry_out), 32'(ex_co));
    chk({tag, " ovf"}, 32'(bus.overflow), 32'(ex_ov));
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, " done width"}, 32'(bus.done), 32'd0);
    chk({tag, " idle"}, 32'(bus.busy), 32'd0);
    chk({tag, " sum held"}, 32'(bus.sum), 32'(ex_s));
  endtask

  initial begin
    logic [W-1:0] a, b, es, es2;
    logic s, ci, eco, eov, eco2, eov2;
    int cyc;

    rstn = 1'b0;
    drive(8'hA5, 8'h3C, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst sum", 32'(bus.sum), 32'd0);
    chk("rst cout", 32'(bus.carry_out), 32'd0);
    chk("rst ovf", 32'(bus.overflow), 32'd0);
    bus.start = 1'b0;
    rstn = 1'b1;
    @(negedge clk);

    run_op("add", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b1 ^ 1'b1, 1'b1, 0);
    run_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_op("wrap cin", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    run_op("sub", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 0);
    run_op("busy ign", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1);

    // back-to-back: start held through RUN and into DONE
    @(negedge clk);
    drive(8'h12, 8'h34, 1'b0, 1'b0);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!bus.done && cyc < 3 * W);
    chk("b2b first lat", 32'(cyc), 32'(W + 1));
    chk("b2b first sum", 32'(bus.sum), 32'h46);
    drive(8'h80, 8'h01, 1'b1, 1'b0);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus.start = 1'b0;
    end while (!bus.done && cyc < 3 * W);
    chk("b2b gap", 32'(cyc), 32'(W + 1));
    chk("b2b sum", 32'(bus.sum), 32'h7F);
    chk("b2b cout", 32'(bus.carry_out), 32'd1);
    chk("b2b ovf", 32'(bus.overflow), 32'd1);
    @(negedge clk);
    chk("b2b end", 32'(bus.busy), 32'd0);

    // reset during the fourth RUN cycle
    @(negedge clk);
    drive(8'h11, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid rst busy", 32'(bus.busy), 32'd0);
    chk("mid rst sum", 32'(bus.sum), 32'd0);
    chk("mid rst cout", 32'(bus.carry_out), 32'd0);
    chk("mid rst ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (i == W) rstn = 1'b1;
      chk("mid rst no done", 32'(bus.done), 32'd0);
    end
    run_op("post rst", 8'hC8, 8'h64, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      s  = 1'($urandom);
      ci = 1'($urandom);
      model(a, b, s, ci, es, eco, eov);
      run_op($sformatf("rand%0d", i), a, b, s, ci, es, eco, eov,
             1'($urandom));
    end

    model(8'h80, 8'h80, 1'b0, 1'b0, es2, eco2, eov2);
    run_op("min+min", 8'h80, 8'h80, 1'b0, 1'b0, es2, eco2, eov2, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
